line_mem_ctrl: RTL and testbench

- Line-granular backing data memory with controller, directly downstream of the data cache bank.
- Serves the bank's allocate (line read) and write-back (line write) requests over a level-held request / single-pulse response handshake, with fixed configurable latency.
- Stores whole 128-bit lines indexed by addr[…:4]; word and byte offsets are ignored.

---
 rtl/line_mem_ctrl_if.sv | 31 +++
 rtl/line_mem_ctrl.sv | 98 +++++++++
 tb/tb_line_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_ctrl_if.sv
// Line memory bus: level-held requests from the cache bank,
// single-pulse responses back from the line memory controller.
interface line_mem_ctrl_if;
    logic         req_read;
    logic         req_write;
    logic [31:0]  addr;
    logic [127:0] wr_line;
    logic [127:0] rd_line;
    logic         data_ready;
    logic         write_back_complete;

    modport master (
        output req_read,
        output req_write,
        output addr,
        output wr_line,
        input  rd_line,
        input  data_ready,
        input  write_back_complete
    );

    modport slave (
        input  req_read,
        input  req_write,
        input  addr,
        input  wr_line,
        output rd_line,
        output data_ready,
        output write_back_complete
    );
endinterface

// File: rtl/line_mem_ctrl.sv
// Line-granular backing memory behind the data cache bank.
// Fixed-latency line read/write with a one-cycle cooldown.
module line_mem_ctrl #(
    parameter int LATENCY   = 4,
    parameter int NUM_LINES = 256,
    parameter int IDX_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    line_mem_ctrl_if.slave      bus,
    output logic                busy,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        COOLDOWN
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic [127:0]       wr_buf;
    logic [127:0]       mem [NUM_LINES];

    // Offset bits and bits above the index only alias lines.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:IDX_W+4], bus.addr[3:0]};

    // Controller FSM, storage array and registered responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            idx                     <= '0;
            wr_buf                  <= '0;
            busy                    <= 1'b0;
            rd_count                <= '0;
            wr_count                <= '0;
            bus.rd_line             <= '0;
            bus.data_ready          <= 1'b0;
            bus.write_back_complete <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            bus.data_ready          <= 1'b0;
            bus.write_back_complete <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_write || bus.req_read) begin
                        idx    <= bus.addr[IDX_W+3:4];
                        wr_buf <= bus.wr_line;
                        cnt    <= CNT_INIT;
                        busy   <= 1'b1;
                        // Write wins; a held read is taken later.
                        state  <= bus.req_write ? WR_WAIT : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        bus.rd_line    <= mem[idx];
                        bus.data_ready <= 1'b1;
                        rd_count       <= rd_count + 16'd1;
                        state          <= COOLDOWN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 4'd0) begin
                        mem[idx]                <= wr_buf;
                        bus.write_back_complete <= 1'b1;
                        wr_count                <= wr_count + 16'd1;
                        state                   <= COOLDOWN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                COOLDOWN: begin
                    // Swallow the cache's stale request level.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed self-checking bench for line_mem_ctrl.
// Inputs change on negedge, outputs sampled on negedge.
module tb_line_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int tests;
    int fails;

    line_mem_ctrl_if bus ();

    line_mem_ctrl #(
        .LATENCY   (4),
        .NUM_LINES (256),
        .IDX_W     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .busy     (busy),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] L_BEEF =
        128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] L_55 = {16{8'h55}};
    localparam logic [127:0] L_AA = {16{8'hAA}};
    localparam logic [127:0] L_FF = {128{1'b1}};

    task automatic idle_inputs();
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.addr      = '0;
        bus.wr_line   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits up to 32 negedges for a pulse; cyc=-1 on timeout.
    task automatic wait_pulse(input bit sel_wr, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if ((sel_wr ? bus.write_back_complete
                        : bus.data_ready) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({bus.rd_line, bus.data_ready, bus.write_back_complete,
             busy, rd_count, wr_count} !== '0) begin
            fails++;
            $display("FAIL reset: rd=%h dr=%b wbc=%b busy=%b rc=%0d wc=%0d expected all 0",
                     bus.rd_line, bus.data_ready, bus.write_back_complete,
                     busy, rd_count, wr_count);
        end
    endtask

    task automatic test_read_latency();
        do_reset();
        bus.req_read = 1'b1;
        bus.addr     = 32'h0000_0040;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL rd_busy@T+%0d: got %b expected 1", k, busy);
            end
            tests++;
            if (bus.data_ready !== (k == 4)) begin
                fails++;
                $display("FAIL rd_pulse@T+%0d: got %b expected %b",
                         k, bus.data_ready, (k == 4));
            end
        end
        tests++;
        if (bus.rd_line !== '0 || rd_count !== 16'd1) begin
            fails++;
            $display("FAIL rd_data: rd=%h rc=%0d expected 0 and 1",
                     bus.rd_line, rd_count);
        end
        bus.req_read = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.data_ready !== 1'b0) begin
            fails++;
            $display("FAIL rd_single_pulse: got %b expected 0", bus.data_ready);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rd_count !== 16'd1) begin
            fails++;
            $display("FAIL rd_done: busy=%b rc=%0d expected 0 and 1",
                     busy, rd_count);
        end
    endtask

    task automatic test_write_then_read();
        int c;
        do_reset();
        bus.req_write = 1'b1;
        bus.addr      = 32'h0000_0070;
        bus.wr_line   = L_BEEF;
        wait_pulse(1'b1, c);
        tests++;
        if (c != 5) begin
            fails++;
            $display("FAIL wr_latency: got %0d expected 5", c);
        end
        bus.req_write = 1'b0;
        bus.wr_line   = '0;
        @(negedge clk);
        bus.req_read = 1'b1;
        bus.addr     = 32'h0000_007C;
        wait_pulse(1'b0, c);
        bus.req_read = 1'b0;
        tests++;
        if (c < 0 || bus.rd_line !== L_BEEF) begin
            fails++;
            $display("FAIL raw_data: got %h (cyc %0d) expected %h",
                     bus.rd_line, c, L_BEEF);
        end
        tests++;
        if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
            fails++;
            $display("FAIL raw_counts: wc=%0d rc=%0d expected 1 and 1",
                     wr_count, rd_count);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int c;
        do_reset();
        bus.req_read  = 1'b1;
        bus.req_write = 1'b1;
        bus.addr      = 32'h0000_0100;
        bus.wr_line   = L_55;
        wait_pulse(1'b1, c);
        tests++;
        if (c != 5 || bus.data_ready !== 1'b0) begin
            fails++;
            $display("FAIL both_write_first: cyc=%0d dr=%b expected 5 and 0",
                     c, bus.data_ready);
        end
        bus.req_write = 1'b0;
        wait_pulse(1'b0, c);
        bus.req_read = 1'b0;
        tests++;
        if (c != 6 || bus.rd_line !== L_55) begin
            fails++;
            $display("FAIL both_read_after: gap=%0d rd=%h expected 6 and %h",
                     c, bus.rd_line, L_55);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_alias();
        int c;
        do_reset();
        bus.req_write = 1'b1;
        bus.addr      = 32'h0000_0010;
        bus.wr_line   = L_AA;
        wait_pulse(1'b1, c);
        bus.req_write = 1'b0;
        @(negedge clk);
        bus.req_read = 1'b1;
        bus.addr     = 32'h0000_1010;
        wait_pulse(1'b0, c);
        bus.req_read = 1'b0;
        tests++;
        if (c < 0 || bus.rd_line !== L_AA) begin
            fails++;
            $display("FAIL alias: got %h (cyc %0d) expected %h",
                     bus.rd_line, c, L_AA);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stale_level();
        int c;
        int n;
        do_reset();
        bus.req_read = 1'b1;
        bus.addr     = 32'h0000_0200;
        wait_pulse(1'b0, c);
        n = (c > 0) ? 1 : 0;
        // Request still high across the cooldown edge.
        @(negedge clk);
        if (bus.data_ready === 1'b1) n++;
        bus.req_read = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.data_ready === 1'b1) n++;
        end
        tests++;
        if (n != 1 || rd_count !== 16'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stale: pulses=%0d rc=%0d busy=%b expected 1, 1, 0",
                     n, rd_count, busy);
        end
    endtask

    task automatic test_reset_mid_write();
        int c;
        int n;
        do_reset();
        n = 0;
        bus.req_write = 1'b1;
        bus.addr      = 32'h0000_0030;
        bus.wr_line   = L_FF;
        @(negedge clk);
        @(negedge clk);
        reset         = 1'b1;
        bus.req_write = 1'b0;
        @(negedge clk);
        if (bus.write_back_complete === 1'b1) n++;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.write_back_complete === 1'b1) n++;
        end
        tests++;
        if (n != 0 || wr_count !== 16'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_wr: pulses=%0d wc=%0d busy=%b expected 0, 0, 0",
                     n, wr_count, busy);
        end
        bus.req_read = 1'b1;
        bus.addr     = 32'h0000_0030;
        wait_pulse(1'b0, c);
        bus.req_read = 1'b0;
        tests++;
        if (c != 5 || bus.rd_line !== '0) begin
            fails++;
            $display("FAIL rst_mid_wr_read: rd=%h cyc=%0d expected 0 and 5",
                     bus.rd_line, c);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_simultaneous();
        test_alias();
        test_stale_level();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
